jogo_memoria_param: RTL



---
 rtl/jogo_pkg.sv | 36 +++
 rtl/jogo_memoria_param_if.sv | 34 +++
 rtl/detector_jogada.sv | 57 +++++
 rtl/jogo_memoria_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jogo_pkg
// Brief    : Shared constants and helpers for the parametrised memory game:
//            FSM state codes (also shown on db_estado), width helper and the
//            fixed-sequence ROM entry function.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package jogo_pkg;

  // FSM state codes; the numeric values are what the hex display shows
  localparam logic [3:0] C_INICIAL     = 4'h0;
  localparam logic [3:0] C_PREPARA     = 4'h1;
  localparam logic [3:0] C_ESPERA      = 4'h2;
  localparam logic [3:0] C_REGISTRA    = 4'h3;
  localparam logic [3:0] C_COMPARA     = 4'h4;
  localparam logic [3:0] C_PROXIMA     = 4'h5;
  localparam logic [3:0] C_FIM_RODADA  = 4'h6;
  localparam logic [3:0] C_ESCREVE     = 4'h7;
  localparam logic [3:0] C_GRAVA       = 4'h8;
  localparam logic [3:0] C_FIM_GANHOU  = 4'hA;
  localparam logic [3:0] C_FIM_PERDEU  = 4'hB;
  localparam logic [3:0] C_FIM_TIMEOUT = 4'hC;

  // Index width for a counter that must hold 0..n-1; never narrower than 1 bit
  function automatic int calc_w(input int n);
    calc_w = (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bit 'pos' of fixed-sequence entry 'idx': entry k is one-hot bit (k mod n)
  function automatic logic rom_bit(input int idx, input int pos, input int n);
    rom_bit = ((idx % n) == pos);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jogo_memoria_param_if.sv
`default_nettype none
// ============================================================================
// Module   : jogo_memoria_param_if
// Brief    : Player/board-side signal bundle of the memory game. The game
//            controller uses the slave view, the board wrapper the master view.
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface jogo_memoria_param_if #(
  parameter int N_BOTOES = 4,
  parameter int W        = 4
);
  logic                jogar;
  logic                modo;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                pronto;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic [3:0]          db_estado;
  logic [W-1:0]        db_rodada;
  logic [W-1:0]        db_jogada;

  modport slave (
    input  jogar, modo, botoes,
    output leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_jogada
  );

  modport master (
    output jogar, modo, botoes,
    input  leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_jogada
  );
endinterface
`default_nettype wire

// File: rtl/detector_jogada.sv
`default_nettype none
// ============================================================================
// Module   : detector_jogada
// Brief    : Registers the button levels, flags a press when they leave the
//            all-zero state (holding does not repeat), checks one-hotness and
//            keeps the last pressed value.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module detector_jogada #(
  parameter int N_BOTOES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                press,
  output logic                press_valid,
  output logic [N_BOTOES-1:0] play,
  output logic                play_valid
);
  logic [N_BOTOES-1:0] botoes_q, botoes_d;
  logic [N_BOTOES-1:0] prev_q, prev_d;
  logic [N_BOTOES-1:0] play_q, play_d;
  logic                play_valid_q, play_valid_d;

  // Press edge detection and capture of the pressed value
  always_comb begin
    botoes_d     = botoes;
    prev_d       = botoes_q;
    press        = (botoes_q != '0) && (prev_q == '0);
    press_valid  = $onehot(botoes_q);
    play_d       = play_q;
    play_valid_d = play_valid_q;
    if (press) begin
      play_d       = botoes_q;
      play_valid_d = press_valid;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      botoes_q     <= '0;
      prev_q       <= '0;
      play_q       <= '0;
      play_valid_q <= 1'b0;
    end else begin
      botoes_q     <= botoes_d;
      prev_q       <= prev_d;
      play_q       <= play_d;
      play_valid_q <= play_valid_d;
    end
  end

  assign play       = play_q;
  assign play_valid = play_valid_q;
endmodule
`default_nettype wire

// File: rtl/jogo_memoria_param.sv
`default_nettype none
// ============================================================================
// Module   : jogo_memoria_param
// Brief    : Memory-game controller. The player repeats a growing sequence
//            over N_RODADAS rounds, either from a fixed ROM (modo=0) or from
//            entries the player appends at the end of each round (modo=1).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module jogo_memoria_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 150000000
) (
  input logic                 clock,
  input logic                 reset,
  jogo_memoria_param_if.slave bus
);
  localparam int W  = calc_w(N_RODADAS);
  localparam int CW = calc_w(TIMEOUT_CICLOS);
  localparam logic [CW-1:0] C_CONT_MAX   = CW'(TIMEOUT_CICLOS - 1);
  localparam logic [W-1:0]  C_RODADA_MAX = W'(N_RODADAS - 1);

  logic [3:0]          state_q, state_d;
  logic [W-1:0]        rodada_q, rodada_d;
  logic [W-1:0]        jogada_q, jogada_d;
  logic [CW-1:0]       count_q, count_d;
  logic                modo_q, modo_d;
  logic [N_BOTOES-1:0] leds_q, leds_d;
  logic [N_BOTOES-1:0] mem_q [N_RODADAS];
  logic [N_BOTOES-1:0] mem_d [N_RODADAS];

  logic                w_press;
  logic                w_press_valid;
  logic [N_BOTOES-1:0] w_play;
  logic                w_play_valid;
  logic [N_BOTOES-1:0] w_rom;
  logic [N_BOTOES-1:0] w_esperado;
  logic                w_ultima;
  logic                w_expirou;

  detector_jogada #(
    .N_BOTOES (N_BOTOES)
  ) u_detector (
    .clock       (clock),
    .reset       (reset),
    .botoes      (bus.botoes),
    .press       (w_press),
    .press_valid (w_press_valid),
    .play        (w_play),
    .play_valid  (w_play_valid)
  );

  // Expected entry for the current play and the end-of-round condition
  always_comb begin
    w_rom = '0;
    for (int b = 0; b < N_BOTOES; b++) begin
      w_rom[b] = rom_bit(int'(jogada_q), b, N_BOTOES);
    end
    w_esperado = modo_q ? mem_q[jogada_q] : w_rom;
    // In written mode the round's newest entry is appended, not repeated
    w_ultima   = modo_q ? (jogada_q == (rodada_q - W'(1))) : (jogada_q == rodada_q);
    w_expirou  = (count_q == C_CONT_MAX);
  end

  // Next-state logic: FSM, round/play indices, timeout counter, memory
  always_comb begin
    state_d  = state_q;
    rodada_d = rodada_q;
    jogada_d = jogada_q;
    modo_d   = modo_q;
    leds_d   = leds_q;
    mem_d    = mem_q;
    // Counter only runs while waiting for a press and saturates at the limit;
    // any other state clears it, so every entry to a waiting state starts at 0
    count_d  = '0;
    if ((state_q == C_ESPERA) || (state_q == C_ESCREVE)) begin
      count_d = w_expirou ? count_q : (count_q + CW'(1));
    end

    case (state_q)
      C_INICIAL: begin
        if (bus.jogar) state_d = C_PREPARA;
      end
      C_PREPARA: begin
        rodada_d = '0;
        jogada_d = '0;
        modo_d   = bus.modo;
        state_d  = bus.modo ? C_ESCREVE : C_ESPERA;
      end
      C_ESPERA: begin
        if (w_press)        state_d = C_REGISTRA;
        else if (w_expirou) state_d = C_FIM_TIMEOUT;
      end
      C_REGISTRA: begin
        leds_d  = w_play;
        state_d = C_COMPARA;
      end
      C_COMPARA: begin
        if (!w_play_valid || (leds_q != w_esperado)) state_d = C_FIM_PERDEU;
        else if (w_ultima)                           state_d = C_FIM_RODADA;
        else                                         state_d = C_PROXIMA;
      end
      C_PROXIMA: begin
        jogada_d = jogada_q + W'(1);
        state_d  = C_ESPERA;
      end
      C_FIM_RODADA: begin
        if (modo_q) begin
          state_d = C_ESCREVE;
        end else if (rodada_q == C_RODADA_MAX) begin
          state_d = C_FIM_GANHOU;
        end else begin
          rodada_d = rodada_q + W'(1);
          jogada_d = '0;
          state_d  = C_ESPERA;
        end
      end
      C_ESCREVE: begin
        if (w_press)        state_d = w_press_valid ? C_GRAVA : C_FIM_PERDEU;
        else if (w_expirou) state_d = C_FIM_TIMEOUT;
      end
      C_GRAVA: begin
        mem_d[rodada_q] = w_play;
        leds_d          = w_play;
        if (rodada_q == C_RODADA_MAX) begin
          state_d = C_FIM_GANHOU;
        end else begin
          rodada_d = rodada_q + W'(1);
          jogada_d = '0;
          state_d  = C_ESPERA;
        end
      end
      C_FIM_GANHOU, C_FIM_PERDEU, C_FIM_TIMEOUT: begin
        if (bus.jogar) state_d = C_PREPARA;
      end
      default: begin
        state_d = C_INICIAL;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= C_INICIAL;
      rodada_q <= '0;
      jogada_q <= '0;
      count_q  <= '0;
      modo_q   <= 1'b0;
      leds_q   <= '0;
      for (int i = 0; i < N_RODADAS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rodada_q <= rodada_d;
      jogada_q <= jogada_d;
      count_q  <= count_d;
      modo_q   <= modo_d;
      leds_q   <= leds_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.leds      = leds_q;
  assign bus.ganhou    = (state_q == C_FIM_GANHOU);
  assign bus.timeout   = (state_q == C_FIM_TIMEOUT);
  assign bus.perdeu    = (state_q == C_FIM_PERDEU) || (state_q == C_FIM_TIMEOUT);
  assign bus.pronto    = (state_q == C_FIM_GANHOU) || (state_q == C_FIM_PERDEU) ||
                         (state_q == C_FIM_TIMEOUT);
  assign bus.db_estado = state_q;
  assign bus.db_rodada = rodada_q;
  assign bus.db_jogada = jogada_q;
endmodule
`default_nettype wire
